// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//
// Shared definitions for the multi-channel debouncer:
//   - deb_state_t : per-channel FSM state encoding. Bit 1 of the encoding is
//                   the debounced level and bit 0 marks a CHECK state.
//   - DEF_*       : default values for the debouncer parameters.
// -----------------------------------------------------------------------------
package debounce_pkg;

   typedef enum logic [1:0] {
      LOW        = 2'd0,
      CHECK_HIGH = 2'd1,
      HIGH       = 2'd2,
      CHECK_LOW  = 2'd3
   } deb_state_t;

   localparam int DEF_N_CH        = 4;
   localparam int DEF_CNT_W       = 16;
   localparam int DEF_SYNC_STAGES = 2;

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//
// One debounce lane: input synchroniser, 4-state debounce FSM, saturating
// stability counter and (optionally) registered edge strobes.
//
// Optional feature macro: DEBOUNCE_EDGE_EN adds rise_pulse / fall_pulse.
//
// Parameters
//   CNT_W        width of the stability counter and threshold
//   SYNC_STAGES  synchroniser depth (2..4)
//
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous reset, active low
//   EN           global enable; low aborts a pending check and blocks new ones
//   thr_m1       stability threshold minus one (threshold already clamped >= 1)
//   noisy_in     raw asynchronous input
//   deb_out      registered debounced level
//   busy         registered, high while a CHECK state is active
//   rise_pulse   one-cycle strobe with the debounced 0->1 change (macro only)
//   fall_pulse   one-cycle strobe with the debounced 1->0 change (macro only)
// -----------------------------------------------------------------------------
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic [CNT_W-1:0] thr_m1,
   input  logic             noisy_in,
   output logic             deb_out,
`ifdef DEBOUNCE_EDGE_EN
   output logic             busy,
   output logic             rise_pulse,
   output logic             fall_pulse
`else
   output logic             busy
`endif
);

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;

   deb_state_t             state_q;
   deb_state_t             state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   deb_q;
   logic                   busy_q;

   // ---- synchroniser stage ----
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // ---- debounce FSM: next state ----
   // The counter starts at 0 on entry to a CHECK state, so reaching
   // thr_m1 means the input has been seen steady for thr cycles. The >=
   // compare lets a threshold lowered mid-check finish on the next edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         LOW: begin
            if (EN && sync) begin
               state_d = CHECK_HIGH;
               cnt_d   = '0;
            end
         end
         CHECK_HIGH: begin
            if (!EN || !sync) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (cnt_q >= thr_m1) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else begin
               cnt_d   = sat_inc(cnt_q);
            end
         end
         HIGH: begin
            if (EN && !sync) begin
               state_d = CHECK_LOW;
               cnt_d   = '0;
            end
         end
         CHECK_LOW: begin
            if (!EN || sync) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q >= thr_m1) begin
               state_d = LOW;
               cnt_d   = '0;
            end else begin
               cnt_d   = sat_inc(cnt_q);
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
         end
      endcase
   end

   // ---- FSM / output register stage ----
   // Outputs are registered from the next state so they change on the same
   // edge as the state itself.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= LOW;
         cnt_q   <= '0;
         deb_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         deb_q   <= (state_d == HIGH) || (state_d == CHECK_LOW);
         busy_q  <= (state_d == CHECK_HIGH) || (state_d == CHECK_LOW);
      end
   end

   assign deb_out = deb_q;
   assign busy    = busy_q;

`ifdef DEBOUNCE_EDGE_EN
   logic rise_q;
   logic fall_q;

   // ---- edge strobe stage ----
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= (state_q == CHECK_HIGH) && (state_d == HIGH);
         fall_q <= (state_q == CHECK_LOW)  && (state_d == LOW);
      end
   end

   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
`endif

endmodule : debounce_channel

// File: rtl/multi_ch_debouncer.sv
// -----------------------------------------------------------------------------
// multi_ch_debouncer
//
// N_CH independent debounce lanes sharing a runtime stability threshold.
//
// Optional feature macro: DEBOUNCE_EDGE_EN adds the rise_pulse / fall_pulse
// edge strobe ports.
//
// Parameters
//   N_CH         number of channels (1..32)
//   CNT_W        width of stable_cycles and the per-channel counters
//   SYNC_STAGES  synchroniser depth (2..4)
//
// Ports
//   CLK            system clock, rising edge
//   RST            asynchronous reset, active low
//   EN             global enable
//   stable_cycles  required stable time in clocks (0 behaves as 1)
//   noisy_in       raw asynchronous inputs, one per channel
//   deb_out        registered debounced levels
//   busy           registered, high while a channel is checking a change
//   rise_pulse     one-cycle strobe per debounced rising change (macro only)
//   fall_pulse     one-cycle strobe per debounced falling change (macro only)
// -----------------------------------------------------------------------------
module multi_ch_debouncer
   import debounce_pkg::*;
#(
   parameter int N_CH        = DEF_N_CH,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic [CNT_W-1:0] stable_cycles,
   input  logic [N_CH-1:0]  noisy_in,
   output logic [N_CH-1:0]  deb_out,
`ifdef DEBOUNCE_EDGE_EN
   output logic [N_CH-1:0]  busy,
   output logic [N_CH-1:0]  rise_pulse,
   output logic [N_CH-1:0]  fall_pulse
`else
   output logic [N_CH-1:0]  busy
`endif
);

   // Threshold is clamped to >= 1 and handed to the lanes minus one, which
   // is the terminal count value of a counter that starts at 0.
   logic [CNT_W-1:0] thr_m1;

   assign thr_m1 = (stable_cycles == '0) ? '0 : stable_cycles - CNT_W'(1);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .CLK         (CLK),
         .RST         (RST),
         .EN          (EN),
         .thr_m1      (thr_m1),
         .noisy_in    (noisy_in[i]),
         .deb_out     (deb_out[i]),
`ifdef DEBOUNCE_EDGE_EN
         .busy        (busy[i]),
         .rise_pulse  (rise_pulse[i]),
         .fall_pulse  (fall_pulse[i])
`else
         .busy        (busy[i])
`endif
      );
   end

endmodule : multi_ch_debouncer

// File: doc/multi_ch_debouncer.md
MULTI_CH_DEBOUNCER -- requirements
Module: multi_ch_debouncer

Interface
REQ-001 Parameter N_CH, default 4, number of independent debounce channels (1..32).
REQ-002 Parameter CNT_W, default 16, width of per-channel stability counter and threshold.
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-004 CLK  input  1  system clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 EN  input  1  global enable; 0 aborts pending checks and freezes outputs.
REQ-007 stable_cycles  input  CNT_W  runtime stability threshold in clocks; 0 treated as 1.
REQ-008 noisy_in  input  N_CH  asynchronous raw inputs, one bit per channel.
REQ-009 deb_out  output  N_CH  debounced level per channel, registered.
REQ-010 busy  output  N_CH  1 while channel is in a CHECK state, registered.
REQ-011 rise_pulse / fall_pulse  output  N_CH each  one-cycle edge strobes; present only with DEBOUNCE_EDGE_EN.

Function
REQ-012 Each channel SHALL pass noisy_in[i] through a SYNC_STAGES flop chain; the last stage is sync[i].
REQ-013 Each channel SHALL run a 4-state FSM: LOW, CHECK_HIGH, HIGH, CHECK_LOW.
REQ-014 LOW: sync=1 and EN=1 -> CHECK_HIGH, counter cleared to 0; else stay.
REQ-015 CHECK_HIGH: sync=0 -> LOW immediately (abort, no timer wait); sync=1 and count >= thr-1 -> HIGH; else count+1.
REQ-016 HIGH and CHECK_LOW SHALL mirror REQ-014/015 with polarity inverted.
REQ-017 thr = max(stable_cycles,1), sampled live each cycle; lowering it mid-check SHALL complete on the next edge via the >= compare.
REQ-018 Counter SHALL saturate at all-ones, never wrap.
REQ-019 deb_out[i] = 1 in HIGH and CHECK_LOW, 0 in LOW and CHECK_HIGH; busy[i] = 1 in CHECK states.
REQ-020 Latency: clean input edge -> deb_out change after exactly SYNC_STAGES + 1 + thr rising edges.
REQ-021 EN=0 SHALL force any CHECK state back to its originating stable state next edge, clear counter, block new checks; sync chain keeps running.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels handled in parallel with no arbitration.

Reset
REQ-023 RST low SHALL asynchronously set all FSMs to LOW, counters and sync flops to 0, deb_out/busy/rise_pulse/fall_pulse to 0.
REQ-024 Reset release mid-bounce SHALL restart from LOW; no output edge produced by reset itself.

Configuration
REQ-025 With DEBOUNCE_EDGE_EN defined: rise_pulse[i] high for exactly one cycle on the edge where CHECK_HIGH -> HIGH, fall_pulse[i] likewise for CHECK_LOW -> LOW, both registered, aligned with deb_out change.
REQ-026 Without DEBOUNCE_EDGE_EN: ports rise_pulse/fall_pulse and their logic SHALL be absent.

Structure
REQ-027 Package debounce_pkg SHALL hold the state enum (LOW=0, CHECK_HIGH=1, HIGH=2, CHECK_LOW=3) and default parameter constants.
REQ-028 Sub-module debounce_channel (sync chain, FSM, counter, edge logic) SHALL be instantiated N_CH times via generate.

Verification
REQ-029 stable_cycles=4, clean 0->1 on ch0 -> deb_out[0] rises after 7 edges (SYNC_STAGES=2), rise_pulse[0] one cycle, busy[0] high 4 cycles.
REQ-030 stable_cycles=8, ch1 toggles every 3 clocks for 40 clocks then holds 1 -> no deb_out[1] change during bounce; rises 11 edges after final edge.
REQ-031 ch2 in CHECK_LOW, EN driven 0 -> next edge back to HIGH, busy[2]=0, deb_out[2] stays 1, no fall_pulse.
REQ-032 stable_cycles=0 -> behaves as 1: deb_out follows sync with 4-edge latency.
REQ-033 stable_cycles=100, ch3 at count 50, stable_cycles changed to 10 -> HIGH on next edge; then RST pulsed low mid-CHECK_LOW -> all outputs 0 asynchronously.
REQ-034 All N_CH channels switched on same edge -> all deb_out bits and pulses assert on the same cycle.
